addsub_flag_fifo: RTL and testbench
===================================

Name: addsub_flag_fifo

Overview:
- Downstream stage of the 4-bit adder/subtractor. Captures each result (sum, carry-out, mode) and derives status flags Z/N/C/V.
- Stores {sum, flags} in a small FIFO.
- Presents the entries to the next consumer with a valid/ready handshake, decoupling the combinational arithmetic path from a consumer that may stall.

Parameters:
- WIDTH, 4, sum width; matches the adder/subtractor data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CW, 3, count width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream result valid this cycle
- in_ready  output  1  stage can accept a result
- s  input  WIDTH  sum from the adder/subtractor
- cout  input  1  carry-out from the adder/subtractor
- mode  input  1  the cin/mode bit driven to the adder/subtractor; 0 = add, 1 = subtract (a + ~b + 1)
- a_msb  input  1  MSB of operand a, used for overflow
- b_msb  input  1  MSB of operand b (uninverted), used for overflow
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts the head entry
- out_sum  output  WIDTH  head entry sum
- out_z  output  1  head entry zero flag
- out_n  output  1  head entry negative flag
- out_c  output  1  head entry carry/borrow flag
- out_v  output  1  head entry signed-overflow flag
- count  output  CW  number of occupied entries

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - Pointers and count go to 0.
  - out_valid=0, in_ready=1.
  - out_sum and all flags read 0.
  - Stored contents are discarded.
  - Reset asserted mid-transfer drops every entry, including one being pushed or popped in that cycle.
- Flags are computed combinationally at push time and stored with the sum:
  - Z = (s == 0).
  - N = s[WIDTH-1].
  - C = cout when mode=0. C = ~cout when mode=1, meaning borrow.
  - V when mode=0: (a_msb == b_msb) && (s[WIDTH-1] != a_msb).
  - V when mode=1: (a_msb != b_msb) && (s[WIDTH-1] != a_msb).
- Push occurs when in_valid && in_ready on a rising clk edge. Pop occurs when out_valid && out_ready on a rising clk edge.
- in_ready = (count != DEPTH). There is no write-through when full: a push attempted while full is not taken, and upstream must hold its inputs.
- out_valid = (count != 0).
- The output is first-word fall-through: out_sum and the flags always reflect the head entry when out_valid=1, and read 0 when empty.
- Latency: a push into an empty FIFO gives out_valid=1 in the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop:
  - When 0 < count < DEPTH: both happen; count is unchanged.
  - When count == 0: only the push happens, since out_valid=0.
  - When count == DEPTH: only the pop happens, since in_ready=0. count drops by 1, and in_ready=1 on the next cycle.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 without loss.
- A pop while empty or a push while full is ignored; no state changes.
- The head entry and count are stable while out_valid=1 and out_ready=0, i.e. the consumer is stalled.

Test Plan:
- Reset, then push s=4'b0010, cout=1, mode=0, a_msb=1, b_msb=1 (8 + 10), with out_ready=1 -> the cycle after the push: out_valid=1, out_sum=2, Z=0, N=0, C=1, V=1. Next edge pops it; count returns to 0.
- Push s=4'b1110, cout=0, mode=1, a_msb=1, b_msb=1 (8 - 10), with out_ready=1 -> out_sum=14, Z=0, N=1, C=1 (borrow), V=0.
- out_ready=0; push 5 consecutive results with sums 1, 2, 3, 4, 5 -> count reaches 4, in_ready=0, the 5th is not accepted while upstream holds it. Then set out_ready=1 -> pops return 1, 2, 3, 4, then the held 5 is accepted and returned. Order preserved across pointer wrap.
- While full, push and pop in the same cycle -> only the pop occurs, count=3, in_ready=1 next cycle. With count=2, push and pop together -> count stays 2, order preserved.
- Push s=0, cout=1, mode=1, a_msb=0, b_msb=0 (5 - 5) -> Z=1, N=0, C=0, V=0.
- Fill with 3 entries, assert rst asynchronously mid-cycle -> out_valid=0, count=0, in_ready=1 immediately. After release, a new push appears alone at the head.

Source files
------------

// File: rtl/addsub_flag_fifo.sv
// addsub_flag_fifo: captures adder/subtractor results, derives Z/N/C/V,
// and queues {sum, flags} behind a first-word fall-through valid/ready port.
module addsub_flag_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic             mode,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   push, pop;
  logic   full, empty;
  logic   s_msb;
  entry_t in_entry;
  entry_t head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign s_msb = s[WIDTH-1];

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;

  // A blocked side never moves state: full masks push, empty masks pop.
  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

  // Status flags of the incoming result; C is inverted into a borrow on subtract.
  always_comb begin
    in_entry     = '0;
    in_entry.sum = s;
    in_entry.z   = (s == '0);
    in_entry.n   = s_msb;
    in_entry.c   = mode ? ~cout : cout;
    if (mode) begin
      in_entry.v = (a_msb != b_msb) && (s_msb != a_msb);
    end else begin
      in_entry.v = (a_msb == b_msb) && (s_msb != a_msb);
    end
  end

  // Next pointer and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset drops every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so stale data never reappears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Fall-through head; forced to zero while empty.
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_sum = head.sum;
  assign out_z   = head.z;
  assign out_n   = head.n;
  assign out_c   = head.c;
  assign out_v   = head.v;

endmodule

// File: tb/tb_addsub_flag_fifo.sv
// tb_addsub_flag_fifo: directed plan plus random traffic against
// an arithmetic queue model of the flag FIFO.
module tb_addsub_flag_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             mode;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_z, out_n, out_c, out_v;
  logic [CW-1:0]    count;

  logic [3:0] a_r, b_r;
  logic       m_r;
  logic [4:0] raw;

  assign raw   = {1'b0, a_r} + {1'b0, (m_r ? ~b_r : b_r)} + 5'(m_r);
  assign s     = raw[3:0];
  assign cout  = raw[4];
  assign mode  = m_r;
  assign a_msb = a_r[3];
  assign b_msb = b_r[3];

  addsub_flag_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .mode(mode),
    .a_msb(a_msb), .b_msb(b_msb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum),
    .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sum;
    logic [3:0] f;
  } ent_t;

  ent_t model[$];
  int   popped[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_ent(int a, int b, bit m);
    ent_t e;
    int r, res, sa, sb, sr;
    r   = m ? a - b : a + b;
    res = r & 15;
    sa  = (a >= 8) ? a - 16 : a;
    sb  = (b >= 8) ? b - 16 : b;
    sr  = m ? sa - sb : sa + sb;
    e.sum  = res;
    e.f[3] = (res == 0);
    e.f[2] = (res >= 8);
    e.f[1] = m ? (a < b) : (r > 15);
    e.f[0] = (sr > 7) || (sr < -8);
    return e;
  endfunction

  task automatic compare(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(model.size() != 0));
    check({tag, ".ready"}, 32'(in_ready), 32'(model.size() != DEPTH));
    check({tag, ".count"}, 32'(count), 32'(model.size()));
    if (model.size() != 0) begin
      check({tag, ".sum"}, 32'(out_sum), 32'(model[0].sum));
      check({tag, ".flags"}, 32'({out_z, out_n, out_c, out_v}),
            32'(model[0].f));
    end else begin
      check({tag, ".sum0"}, 32'({out_sum, out_z, out_n, out_c, out_v}),
            32'(0));
    end
  endtask

  task automatic step(input string tag);
    bit   push, pop;
    ent_t e;
    push = in_valid && (model.size() < DEPTH);
    pop  = out_ready && (model.size() > 0);
    e    = ref_ent(int'(a_r), int'(b_r), m_r);
    @(posedge clk);
    if (pop) begin
      popped.push_back(model[0].sum);
      void'(model.pop_front());
    end
    if (push) model.push_back(e);
    #1;
    compare(tag);
  endtask

  task automatic set_in(input int a, input int b, input bit m,
                        input bit v);
    a_r      = 4'(a);
    b_r      = 4'(b);
    m_r      = m;
    in_valid = v;
  endtask

  initial begin
    rst = 1;
    set_in(0, 0, 0, 0);
    out_ready = 0;
    #12;
    compare("reset");
    @(negedge clk);
    rst = 0;
    #1;
    compare("post_reset");

    // 8 + 10
    out_ready = 1;
    set_in(8, 10, 0, 1);
    step("add");
    check("add.flags_zncv", 32'({out_z, out_n, out_c, out_v}), 32'b0011);
    check("add.sum_const", 32'(out_sum), 32'd2);
    set_in(0, 0, 0, 0);
    step("add_pop");
    check("add_pop.count", 32'(count), 32'd0);

    // 8 - 10
    set_in(8, 10, 1, 1);
    step("sub");
    check("sub.flags_zncv", 32'({out_z, out_n, out_c, out_v}), 32'b0110);
    check("sub.sum_const", 32'(out_sum), 32'd14);
    set_in(0, 0, 0, 0);
    step("sub_pop");

    // fill with 1..4, hold 5 while full
    out_ready = 0;
    popped.delete();
    for (int k = 1; k <= 4; k++) begin
      set_in(k, 0, 0, 1);
      step("fill");
    end
    set_in(5, 0, 0, 1);
    step("full_hold");
    step("full_hold");
    check("full.count", 32'(count), 32'd4);
    check("full.ready", 32'(in_ready), 32'd0);
    out_ready = 1;
    step("full_pushpop");
    check("full_pushpop.count", 32'(count), 32'd3);
    check("full_pushpop.ready", 32'(in_ready), 32'd1);
    step("held_push");
    set_in(0, 0, 0, 0);
    for (int k = 0; k < 8 && model.size() != 0; k++) step("drain");
    check("drain.empty", 32'(out_valid), 32'd0);
    check("order.n", 32'(popped.size()), 32'd5);
    for (int k = 0; k < 5 && k < popped.size(); k++)
      check("order.val", 32'(popped[k]), 32'(k + 1));

    // push+pop at count 2
    out_ready = 0;
    set_in(6, 1, 0, 1); step("two");
    set_in(9, 2, 1, 1); step("two");
    out_ready = 1;
    set_in(3, 3, 0, 1); step("two_pushpop");
    check("two_pushpop.count", 32'(count), 32'd2);
    set_in(0, 0, 0, 0);
    for (int k = 0; k < 8 && model.size() != 0; k++) step("drain2");

    // 5 - 5
    set_in(5, 5, 1, 1);
    step("zero");
    check("zero.flags_zncv", 32'({out_z, out_n, out_c, out_v}), 32'b1000);
    set_in(0, 0, 0, 0);
    step("zero_pop");

    // async reset with three entries queued
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_in(k + 7, k, 0, 1);
      step("prefill");
    end
    set_in(1, 1, 0, 1);
    #2 rst = 1;
    #1;
    model.delete();
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    check("arst.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 0;
    set_in(3, 4, 0, 1);
    step("after_rst");
    check("after_rst.count", 32'(count), 32'd1);
    check("after_rst.sum", 32'(out_sum), 32'd7);
    set_in(0, 0, 0, 0);
    out_ready = 1;
    step("after_rst_pop");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      set_in(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 60));
      out_ready = ($urandom_range(0, 99) < 50);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
